// File: rtl/midi_tx.sv
// midi_tx: byte FIFO feeding an 8N1 MIDI UART serializer (31.25 kbaud by default).
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel status bytes at push time.
module midi_tx #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD       = 31250,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_l,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Byte FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          wr_en;
  logic          push;
  logic          pop;

  // Serializer state
  state_t        state;
  state_t        state_d;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          tx_d;
  logic          bit_end;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = reset_l && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && wr_en;
  assign busy       = !fifo_empty || (state != IDLE);
  assign bit_end    = (cnt == BIT_LAST);

`ifdef MIDI_RUNNING_STATUS_EN
  // Running-status filter: a repeat of the current channel status is handshaken but not buffered
  logic [7:0] last_status;
  logic       is_chan;
  logic       is_common;

  assign is_chan   = (in_byte >= 8'h80) && (in_byte <= 8'hEF);
  assign is_common = (in_byte[7:3] == 5'b11110);
  assign wr_en     = !(is_chan && (in_byte == last_status));

  always_ff @(posedge clock) begin
    if (!reset_l) begin
      last_status <= 8'h00;
    end else if (accept) begin
      if (is_chan) begin
        last_status <= in_byte;
      end else if (is_common) begin
        last_status <= 8'h00;
      end
    end
  end
`else
  assign wr_en = 1'b1;
`endif

  // FIFO pointers and occupancy; a push and a pop in one cycle leave the count unchanged
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_byte;
    end
  end

  // Serializer state register
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + TW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    pop       = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = shift >> 1;
            tx_d      = shift[1];
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
